// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution sequencer.
// Contents: FSM state enum, default geometry, output count, clog2 helper.
package conv_pkg;

  typedef enum logic [2:0] {
    StLoad,
    StClear,
    StCompute,
    StDrain,
    StOut
  } state_e;

  localparam int unsigned LenXDef = 8;
  localparam int unsigned LenFDef = 4;
  // Outputs produced per vector with the default geometry.
  localparam int unsigned NUM_OUT = LenXDef - LenFDef + 1;

  // Bits needed to address 'value' distinct locations.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Handshake and datapath-control bundle of the convolution sequencer.
//   s_valid_x/s_ready_x : input sample stream
//   x_wr_en, x_addr     : x memory write strobe / address
//   f_addr              : coefficient ROM address
//   clr_acc, en_acc     : accumulator clear / accumulate
//   m_valid_y/m_ready_y : result stream
// master = sequencer side, slave = environment side.
interface conv_sequencer_if #(
  parameter int unsigned ADDRX = 3,
  parameter int unsigned ADDRF = 2
);
  logic             s_valid_x;
  logic             s_ready_x;
  logic             x_wr_en;
  logic [ADDRX-1:0] x_addr;
  logic [ADDRF-1:0] f_addr;
  logic             clr_acc;
  logic             en_acc;
  logic             m_valid_y;
  logic             m_ready_y;

  modport master (
    input  s_valid_x, m_ready_y,
    output s_ready_x, x_wr_en, x_addr, f_addr, clr_acc, en_acc, m_valid_y
  );

  modport slave (
    output s_valid_x, m_ready_y,
    input  s_ready_x, x_wr_en, x_addr, f_addr, clr_acc, en_acc, m_valid_y
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Counter and address generator for the convolution sequencer.
// Holds the write counter, window base i and tap index j; all counter moves
// come from FSM strobes.
//   clk, reset          : clock, async active-high reset
//   wr_inc/wr_clr       : advance / clear write counter
//   i_inc/i_clr         : advance / clear window base
//   j_inc/j_clr         : advance / clear tap index
//   sel_wr              : x_addr shows write counter instead of i+j
//   x_addr, f_addr      : memory / ROM addresses
//   wr_last/i_last/j_last : terminal-count flags
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned LENX  = 8,
  parameter int unsigned LENF  = 4,
  parameter int unsigned ADDRX = 3,
  parameter int unsigned ADDRF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_inc,
  input  logic             wr_clr,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic             j_inc,
  input  logic             j_clr,
  input  logic             sel_wr,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             wr_last,
  output logic             i_last,
  output logic             j_last
);

  localparam int unsigned SW = (ADDRX > ADDRF) ? ADDRX : ADDRF;

  logic [ADDRX-1:0] wr_q, wr_d;
  logic [ADDRX-1:0] i_q, i_d;
  logic [ADDRF-1:0] j_q, j_d;
  logic [SW-1:0]    sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      i_q  <= '0;
      j_q  <= '0;
    end else begin
      wr_q <= wr_d;
      i_q  <= i_d;
      j_q  <= j_d;
    end
  end

  always_comb begin
    wr_d = wr_q;
    i_d  = i_q;
    j_d  = j_q;
    if (wr_clr) wr_d = '0;
    else if (wr_inc) wr_d = wr_q + ADDRX'(1);
    if (i_clr) i_d = '0;
    else if (i_inc) i_d = i_q + ADDRX'(1);
    if (j_clr) j_d = '0;
    else if (j_inc) j_d = j_q + ADDRF'(1);
  end

  // i+j stays below LENX, so truncating back to ADDRX bits is lossless.
  assign sum     = SW'(i_q) + SW'(j_q);
  assign x_addr  = sel_wr ? wr_q : sum[ADDRX-1:0];
  assign f_addr  = j_q;
  assign wr_last = (wr_q == ADDRX'(LENX - 1));
  assign i_last  = (i_q == ADDRX'(LENX - LENF));
  assign j_last  = (j_q == ADDRF'(LENF - 1));

endmodule

// File: rtl/conv_sequencer.sv
// Central controller of the 1-D convolution datapath.
// Loads LENX samples, then for each window base i clears the accumulator,
// streams LENF (x=i+j, f=j) address pairs, drains one cycle for the memory
// read latency and offers the result on the master stream.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : sample/result handshakes and datapath control (master side)
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned LENX  = 8,
  parameter int unsigned LENF  = 4,
  parameter int unsigned ADDRX = 3,
  parameter int unsigned ADDRF = 2
) (
  input  logic              clk,
  input  logic              reset,
  conv_sequencer_if.master  bus
);

  if (LENF == 0 || LENF > LENX) begin : g_bad_len
    $error("conv_sequencer: need 1 <= LENF <= LENX");
  end
  if (clog2(LENX) > ADDRX || clog2(LENF) > ADDRF) begin : g_bad_width
    $error("conv_sequencer: address width too small");
  end

  state_e state_q, state_d;
  logic   issue_q, issue_next;
  logic   s_ready, wr_en;
  logic   wr_inc, wr_clr, i_inc, i_clr, j_inc, j_clr;
  logic   wr_last, i_last, j_last;

  assign s_ready = (state_q == StLoad) && !reset;
  assign wr_en   = bus.s_valid_x && s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoad;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_next;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue_next = 1'b0;
    wr_inc     = 1'b0;
    wr_clr     = 1'b0;
    i_inc      = 1'b0;
    i_clr      = 1'b0;
    j_inc      = 1'b0;
    j_clr      = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (wr_en) begin
          if (wr_last) begin
            wr_clr  = 1'b1;
            i_clr   = 1'b1;
            state_d = StClear;
          end else begin
            wr_inc = 1'b1;
          end
        end
      end
      StClear: begin
        j_clr   = 1'b1;
        state_d = StCompute;
      end
      StCompute: begin
        // Read data for this address arrives next cycle; en_acc follows it.
        issue_next = 1'b1;
        if (j_last) state_d = StDrain;
        else j_inc = 1'b1;
      end
      StDrain: begin
        state_d = StOut;
      end
      StOut: begin
        if (bus.m_ready_y) begin
          if (i_last) begin
            state_d = StLoad;
          end else begin
            i_inc   = 1'b1;
            state_d = StClear;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  conv_addr_gen #(
    .LENX (LENX),
    .LENF (LENF),
    .ADDRX(ADDRX),
    .ADDRF(ADDRF)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .wr_inc (wr_inc),
    .wr_clr (wr_clr),
    .i_inc  (i_inc),
    .i_clr  (i_clr),
    .j_inc  (j_inc),
    .j_clr  (j_clr),
    .sel_wr (state_q == StLoad),
    .x_addr (bus.x_addr),
    .f_addr (bus.f_addr),
    .wr_last(wr_last),
    .i_last (i_last),
    .j_last (j_last)
  );

  assign bus.s_ready_x = s_ready;
  assign bus.x_wr_en   = wr_en;
  assign bus.clr_acc   = (state_q == StClear);
  assign bus.en_acc    = issue_q;
  assign bus.m_valid_y = (state_q == StOut);

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a behavioural x memory / ROM / MAC
// datapath is driven by the DUT controls; expected write addresses, window
// bases and convolution results are queued by the stimulus and popped by a
// separate monitor.
module tb_conv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if #(.ADDRX(3), .ADDRF(2)) bus ();
  conv_sequencer_if #(.ADDRX(2), .ADDRF(2)) bus2 ();

  conv_sequencer #(.LENX(8), .LENF(4), .ADDRX(3), .ADDRF(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  conv_sequencer #(.LENX(4), .LENF(4), .ADDRX(2), .ADDRF(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural datapath: 1-cycle read latency memory and ROM, plain MAC.
  int xmem [8];
  int rom  [4] = '{1, 2, 3, 4};
  int s_data = 0;
  int x_rd = 0, f_rd = 0, acc = 0;

  always @(posedge clk) begin
    if (bus.x_wr_en) xmem[bus.x_addr] <= s_data;
    x_rd <= xmem[bus.x_addr];
    f_rd <= rom[bus.f_addr];
    if (bus.clr_acc) acc <= 0;
    else if (bus.en_acc) acc <= acc + x_rd * f_rd;
  end

  int exp_wa[$];
  int exp_base[$];
  int exp_y[$];
  int hs_cnt = 0;
  int hs2 = 0, en2_cnt = 0, clr2_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event required none", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    int b, y, en_cnt, lat;
    bit after_clr, mv_prev;
    en_cnt = 0; lat = 0; after_clr = 0; mv_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        after_clr = 0; en_cnt = 0; lat = 0; mv_prev = 0;
      end else begin
        if (after_clr) begin
          if (exp_base.size() == 0) miss("window_base");
          else begin
            b = exp_base.pop_front();
            check("window_base", int'(bus.x_addr), b);
            check("first_f_addr", int'(bus.f_addr), 0);
          end
        end
        after_clr = bus.clr_acc;
        if (bus.x_wr_en) begin
          if (exp_wa.size() == 0) miss("write_addr");
          else check("write_addr", int'(bus.x_addr), exp_wa.pop_front());
        end
        if (bus.clr_acc) begin
          en_cnt = 0; lat = 0;
        end else begin
          lat++;
          if (bus.en_acc) en_cnt++;
        end
        if (bus.m_valid_y && !mv_prev) begin
          check("clr_to_valid", lat, 6);
          check("en_pulses", en_cnt, 4);
        end
        if (bus.m_valid_y && bus.m_ready_y) begin
          hs_cnt++;
          if (exp_y.size() == 0) miss("result");
          else begin
            y = exp_y.pop_front();
            check("result", acc, y);
          end
        end
        mv_prev = bus.m_valid_y;
        if (bus2.m_valid_y && bus2.m_ready_y) hs2++;
        if (bus2.en_acc) en2_cnt++;
        if (bus2.clr_acc) clr2_cnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the sample was written.
  task automatic send(input int which, input int v);
    bit ok;
    ok = 0;
    s_data = v;
    if (which == 1) bus.s_valid_x = 1'b1;
    else bus2.s_valid_x = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ((which == 1 && bus.x_wr_en) || (which == 2 && bus2.x_wr_en)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    bit ok;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (hs_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("handshake_timeout", hs_cnt, target);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, int'(bus.s_ready_x), 0);
    check({tag, "_wr_en"}, int'(bus.x_wr_en), 0);
    check({tag, "_x_addr"}, int'(bus.x_addr), 0);
    check({tag, "_f_addr"}, int'(bus.f_addr), 0);
    check({tag, "_clr"}, int'(bus.clr_acc), 0);
    check({tag, "_en"}, int'(bus.en_acc), 0);
    check({tag, "_m_valid"}, int'(bus.m_valid_y), 0);
  endtask

  initial begin
    int v2 [8] = '{2, 0, 1, 3, 1, 1, 0, 2};
    int y2 [5] = '{17, 15, 14, 8, 11};
    int ax, af;
    bit seen;

    bus.s_valid_x  = 1'b1;  // valid during reset must not write
    bus.m_ready_y  = 1'b1;
    bus2.s_valid_x = 1'b0;
    bus2.m_ready_y = 1'b1;

    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    bus.s_valid_x = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", int'(bus.s_ready_x), 1);
    @(posedge clk);
    #1;

    // Vector 1: samples 1..8, filter 1,2,3,4 -> 30,40,50,60,70.
    for (int k = 0; k < 8; k++) exp_wa.push_back(k);
    for (int k = 0; k < 5; k++) begin
      exp_base.push_back(k);
      exp_y.push_back(30 + 10 * k);
    end
    for (int k = 0; k < 8; k++) send(1, k + 1);
    bus.s_valid_x = 1'b0;
    @(negedge clk);
    check("ready_drop_after_load", int'(bus.s_ready_x), 0);
    check("clr_after_load", int'(bus.clr_acc), 1);
    wait_hs(5);
    @(negedge clk);
    check("ready_after_vector", int'(bus.s_ready_x), 1);
    @(posedge clk);
    #1;

    // Vector 2: bubbly input, stray valid during compute, back-pressure.
    for (int k = 0; k < 8; k++) exp_wa.push_back(k);
    for (int k = 0; k < 5; k++) begin
      exp_base.push_back(k);
      exp_y.push_back(y2[k]);
    end
    for (int k = 0; k < 8; k++) begin
      send(1, v2[k]);
      if (k < 7) begin
        bus.s_valid_x = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.s_valid_x = 1'b0;
    wait_hs(6);
    bus.m_ready_y = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.m_valid_y) begin
        seen = 1;
        break;
      end
    end
    check("valid_before_hold", int'(seen), 1);
    ax = int'(bus.x_addr);
    af = int'(bus.f_addr);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", int'(bus.m_valid_y), 1);
      check("hold_en", int'(bus.en_acc), 0);
      check("hold_x_addr", int'(bus.x_addr), ax);
      check("hold_f_addr", int'(bus.f_addr), af);
    end
    @(posedge clk);
    #1;
    bus.m_ready_y = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("clr_after_release", int'(bus.clr_acc), 1);
    wait_hs(10);

    // Vector 3: abandoned by an asynchronous reset mid-COMPUTE.
    for (int k = 0; k < 8; k++) exp_wa.push_back(k);
    exp_base.push_back(0);
    for (int k = 0; k < 8; k++) send(1, k + 5);
    bus.s_valid_x = 1'b0;
    @(posedge clk);
    @(posedge clk);
    bus.s_valid_x = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    bus.s_valid_x = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", int'(bus.s_ready_x), 1);
    @(posedge clk);
    #1;

    // Vector 4: all-ones samples -> 10 per window; writes must restart at 0.
    for (int k = 0; k < 8; k++) exp_wa.push_back(k);
    for (int k = 0; k < 5; k++) begin
      exp_base.push_back(k);
      exp_y.push_back(10);
    end
    for (int k = 0; k < 8; k++) send(1, 1);
    bus.s_valid_x = 1'b0;
    wait_hs(15);

    // LENF == LENX variant: exactly one output, then back to loading.
    for (int k = 0; k < 4; k++) send(2, k);
    bus2.s_valid_x = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("eq_len_outputs", hs2, 1);
    check("eq_len_en_pulses", en2_cnt, 4);
    check("eq_len_clr_pulses", clr2_cnt, 1);
    check("eq_len_ready", int'(bus2.s_ready_x), 1);
    check("dut1_idle_outputs", hs_cnt, 15);

    check("left_results", exp_y.size(), 0);
    check("left_writes", exp_wa.size(), 0);
    check("left_bases", exp_base.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
